// File: rtl/i2c_init_seq.sv
// i2c_init_seq: walks a (reg, data) init table from a synchronous ROM and issues
// one I2C write per entry, with delay entries, NACK retry, watchdog and error reporting.
`default_nettype none

module i2c_init_seq #(
  parameter int         NUM_ENTRIES    = 64,
  parameter logic [6:0] SLAVE_ADDR     = 7'h21,
  parameter int         GAP_CYCLES     = 500,
  parameter int         DELAY_UNIT     = 50000,
  parameter int         MAX_RETRY      = 3,
  parameter int         TIMEOUT_CYCLES = 200000,
  localparam int        IDX_W          = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  output logic [IDX_W-1:0] tbl_addr,
  input  logic [15:0]      tbl_data,
  output logic [6:0]       slave_addr,
  output logic [7:0]       slave_reg_addr,
  output logic [7:0]       data_i,
  output logic             rw,
  output logic             start_tx,
  input  logic             i2c_busy,
  input  logic             i2c_done,
  input  logic             i2c_nack,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [IDX_W-1:0] err_index
);

  localparam int DLY_MAX = 255 * DELAY_UNIT;
  localparam int TMR_A   = (DLY_MAX > TIMEOUT_CYCLES) ? DLY_MAX : TIMEOUT_CYCLES;
  localparam int TMR_MAX = (TMR_A > GAP_CYCLES) ? TMR_A : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WAIT_ROM, S_DECODE, S_ISSUE, S_WAIT_DONE,
    S_GAP, S_DELAY, S_NEXT, S_DONE, S_ERROR
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] index;
  logic [15:0]      entry;
  logic [RTY_W-1:0] retry;
  logic             again;
  logic [TMR_W-1:0] tmr;
  logic [1:0]       pend_code;

  // The index register doubles as the ROM address so data is valid during WAIT_ROM.
  assign tbl_addr = index;
  assign rw       = 1'b0;

  // GAP, DELAY and the watchdog are mutually exclusive, so they share one timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      index          <= '0;
      entry          <= '0;
      retry          <= '0;
      again          <= 1'b0;
      tmr            <= '0;
      pend_code      <= 2'b00;
      slave_addr     <= SLAVE_ADDR;
      slave_reg_addr <= '0;
      data_i         <= '0;
      start_tx       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      err_code       <= 2'b00;
      err_index      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            index <= '0;
            done  <= 1'b0;
            error <= 1'b0;
            busy  <= 1'b1;
            state <= S_FETCH;
          end
        end
        S_FETCH:    state <= S_WAIT_ROM;
        S_WAIT_ROM: begin
          entry <= tbl_data;
          state <= S_DECODE;
        end
        S_DECODE: begin
          if (entry == 16'hFFFF) begin
            state <= S_DONE;
          end else if (entry[15:8] == 8'hFE) begin
            tmr   <= TMR_W'(entry[7:0]) * TMR_W'(DELAY_UNIT) - TMR_W'(1);
            state <= (entry[7:0] == 8'h00) ? S_NEXT : S_DELAY;
          end else begin
            slave_reg_addr <= entry[15:8];
            data_i         <= entry[7:0];
            retry          <= '0;
            again          <= 1'b0;
            start_tx       <= 1'b1;
            tmr            <= TMR_W'(TIMEOUT_CYCLES - 1);
            state          <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tmr <= tmr - 1'b1;
          if (i2c_busy) begin
            start_tx <= 1'b0;
            state    <= S_WAIT_DONE;
          end else if (tmr == '0) begin
            start_tx  <= 1'b0;
            pend_code <= 2'b10;
            state     <= S_ERROR;
          end
        end
        S_WAIT_DONE: begin
          tmr <= tmr - 1'b1;
          if (i2c_done) begin
            if (!i2c_nack) begin
              tmr   <= TMR_W'(GAP_CYCLES - 1);
              state <= S_GAP;
            end else if (retry != RTY_W'(MAX_RETRY)) begin
              retry <= retry + 1'b1;
              again <= 1'b1;
              tmr   <= TMR_W'(GAP_CYCLES - 1);
              state <= S_GAP;
            end else begin
              pend_code <= 2'b01;
              state     <= S_ERROR;
            end
          end else if (tmr == '0) begin
            pend_code <= 2'b10;
            state     <= S_ERROR;
          end
        end
        S_GAP: begin
          if (tmr == '0) begin
            if (again) begin
              again    <= 1'b0;
              start_tx <= 1'b1;
              tmr      <= TMR_W'(TIMEOUT_CYCLES - 1);
              state    <= S_ISSUE;
            end else begin
              state <= S_NEXT;
            end
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_DELAY: begin
          if (tmr == '0) state <= S_NEXT;
          else           tmr   <= tmr - 1'b1;
        end
        S_NEXT: begin
          if (index == IDX_W'(NUM_ENTRIES - 1)) begin
            pend_code <= 2'b11;
            state     <= S_ERROR;
          end else begin
            index <= index + 1'b1;
            state <= S_FETCH;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_ERROR: begin
          error     <= 1'b1;
          err_code  <= pend_code;
          err_index <= index;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_init_seq.sv
// Testbench for i2c_init_seq: ROM + I2C master responder models, table-walk reference model.
`default_nettype none

module tb_i2c_init_seq;

  localparam int         NE     = 4;
  localparam int         IW     = 2;
  localparam logic [6:0] SLV    = 7'h21;
  localparam int         GAP    = 20;
  localparam int         DU     = 50;
  localparam int         MR     = 3;
  localparam int         TO     = 300;
  localparam int         BUDGET = 5000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          go = 1'b0;
  logic [IW-1:0] tbl_addr;
  logic [15:0]   tbl_data;
  logic [6:0]    slave_addr;
  logic [7:0]    slave_reg_addr;
  logic [7:0]    data_i;
  logic          rw;
  logic          start_tx;
  logic          i2c_busy = 1'b0;
  logic          i2c_done = 1'b0;
  logic          i2c_nack = 1'b0;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    err_code;
  logic [IW-1:0] err_index;

  i2c_init_seq #(
    .NUM_ENTRIES(NE), .SLAVE_ADDR(SLV), .GAP_CYCLES(GAP),
    .DELAY_UNIT(DU), .MAX_RETRY(MR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .slave_addr(slave_addr), .slave_reg_addr(slave_reg_addr), .data_i(data_i),
    .rw(rw), .start_tx(start_tx), .i2c_busy(i2c_busy), .i2c_done(i2c_done),
    .i2c_nack(i2c_nack), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .err_index(err_index)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] rom [NE];
  always @(posedge clk) tbl_data <= rom[tbl_addr];

  logic [31:0] nack_pat;
  int          att_cnt;
  bit          hang = 1'b0;
  int          first_start;
  int          last_done_cyc;
  bit          last_done_valid;
  int          go_cyc;
  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];
  bit          exp_done;
  logic [1:0]  exp_code;
  int          exp_idx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Master stand-in: accepts start_tx after a random latency, answers with a NACK pattern.
  initial begin : responder
    int lat;
    int hold;
    forever begin
      @(negedge clk);
      if (start_tx && !hang && !rst) begin
        if (first_start < 0) first_start = cyc;
        if (last_done_valid) chk("gap_min", 32'((cyc - last_done_cyc) >= GAP), 1);
        lat = $urandom_range(0, 3);
        repeat (lat) @(negedge clk);
        chk("start_hold", start_tx, 1);
        chk("slave_addr", slave_addr, SLV);
        chk("rw", rw, 0);
        obs_q.push_back({slave_reg_addr, data_i});
        i2c_busy = 1'b1;
        @(negedge clk);
        chk("start_drop", start_tx, 0);
        hold = $urandom_range(1, 5);
        repeat (hold) @(negedge clk);
        i2c_busy = 1'b0;
        i2c_done = 1'b1;
        i2c_nack = (att_cnt < 32) ? nack_pat[att_cnt] : 1'b0;
        att_cnt++;
        last_done_cyc   = cyc;
        last_done_valid = 1'b1;
        @(negedge clk);
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
      end
    end
  end

  // Reference: the writes the table should produce and how the sequence should end.
  task automatic model();
    int k;
    bit fin;
    exp_q.delete();
    exp_done = 1'b0;
    exp_code = 2'b00;
    exp_idx  = 0;
    k = 0;
    for (int i = 0; i < NE; i++) begin
      if (rom[i] == 16'hFFFF) begin
        exp_done = 1'b1;
        return;
      end
      if (rom[i][15:8] != 8'hFE) begin
        fin = 1'b0;
        for (int a = 0; a <= MR && !fin; a++) begin
          exp_q.push_back(rom[i]);
          if (k < 32 && nack_pat[k]) begin
            if (a == MR) begin
              exp_code = 2'b01;
              exp_idx  = i;
              return;
            end
          end else begin
            fin = 1'b1;
          end
          k++;
        end
      end
    end
    exp_code = 2'b11;
    exp_idx  = NE - 1;
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_start_tx"}, start_tx, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_error"}, error, 0);
    chk({pfx, "_err_code"}, err_code, 0);
    chk({pfx, "_err_index"}, err_index, 0);
    chk({pfx, "_tbl_addr"}, tbl_addr, 0);
    chk({pfx, "_slave_addr"}, slave_addr, SLV);
    chk({pfx, "_reg_addr"}, slave_reg_addr, 0);
    chk({pfx, "_data_i"}, data_i, 0);
    chk({pfx, "_rw"}, rw, 0);
  endtask

  task automatic pulse_go();
    @(negedge clk);
    go = 1'b1;
    go_cyc = cyc;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic run_seq(input logic [15:0] t0, input logic [15:0] t1, input logic [15:0] t2,
                         input logic [15:0] t3, input logic [31:0] nk, input bit spam,
                         input string name);
    int n;
    int m;
    rom[0] = t0; rom[1] = t1; rom[2] = t2; rom[3] = t3;
    nack_pat = nk;
    att_cnt = 0;
    obs_q.delete();
    last_done_valid = 1'b0;
    first_start = -1;
    model();
    pulse_go();
    n = 0;
    while (!(done || error) && n < BUDGET) begin
      @(negedge clk);
      n++;
      if (spam) go = busy && ($urandom_range(0, 7) == 0);
    end
    go = 1'b0;
    chk({name, "_finished"}, 32'(n < BUDGET), 1);
    repeat (2) @(negedge clk);
    chk({name, "_n_tx"}, obs_q.size(), exp_q.size());
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) chk($sformatf("%s_tx%0d", name, i), obs_q[i], exp_q[i]);
    chk({name, "_done"}, done, exp_done);
    chk({name, "_error"}, error, !exp_done);
    chk({name, "_busy"}, busy, 0);
    if (!exp_done) begin
      chk({name, "_err_code"}, err_code, exp_code);
      chk({name, "_err_index"}, err_index, exp_idx);
    end
  endtask

  initial begin : main
    int n;
    int hi;
    logic [15:0] t [NE];
    logic [31:0] nk;
    int r;
    for (int i = 0; i < NE; i++) rom[i] = 16'hFFFF;
    nack_pat = '0;
    att_cnt = 0;
    first_start = -1;
    last_done_valid = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_seq(16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF, 32'h0, 1'b0, "basic");
    run_seq(16'hFE03, 16'h3A04, 16'hFFFF, 16'hFFFF, 32'h0, 1'b0, "delay");
    chk("delay_wait", 32'((first_start - go_cyc) >= 3 * DU), 1);
    run_seq(16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF, 32'h3, 1'b0, "retry2");
    run_seq(16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF, 32'hF, 1'b0, "nack_all");
    run_seq(16'h0102, 16'h0304, 16'h0506, 16'h0708, 32'h0, 1'b0, "overrun");

    // Watchdog: the master never answers.
    rom[0] = 16'h1280; rom[1] = 16'hFFFF;
    hang = 1'b1;
    pulse_go();
    n = 0;
    while (!start_tx && n < 100) begin @(negedge clk); n++; end
    chk("wd_start_seen", 32'(n < 100), 1);
    hi = 0;
    while (start_tx && hi < TO + 50) begin @(negedge clk); hi++; end
    chk("wd_start_len", hi, TO);
    repeat (3) @(negedge clk);
    chk("wd_error", error, 1);
    chk("wd_err_code", err_code, 2'b10);
    chk("wd_err_index", err_index, 0);
    chk("wd_busy", busy, 0);
    hang = 1'b0;

    // Reset while entry 1 is in flight.
    rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'h1055; rom[3] = 16'hFFFF;
    nack_pat = '0;
    att_cnt = 0;
    obs_q.delete();
    last_done_valid = 1'b0;
    pulse_go();
    n = 0;
    while (!(obs_q.size() == 2 && i2c_busy && !start_tx) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_reached", 32'(n < BUDGET), 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("midrst_idle_busy", busy, 0);
    run_seq(16'h1280, 16'h1101, 16'h1055, 16'hFFFF, 32'h0, 1'b1, "restart");

    for (int s = 0; s < 10; s++) begin
      for (int i = 0; i < NE; i++) begin
        r = $urandom_range(0, 9);
        if (r == 0)      t[i] = 16'hFFFF;
        else if (r <= 2) t[i] = {8'hFE, 8'($urandom_range(0, 3))};
        else begin
          t[i] = 16'($urandom);
          if (t[i][15:8] == 8'hFE) t[i][15:8] = 8'h10;
        end
      end
      nk = '0;
      for (int b = 0; b < 32; b++) nk[b] = ($urandom_range(0, 2) == 0);
      run_seq(t[0], t[1], t[2], t[3], nk, s[0], $sformatf("rnd%0d", s));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
